// File: rtl/action_sequencer_if.sv
// Request-side bundle of the action sequencer: two requesters
// offering button commands, with per-requester accept strobes.
interface action_sequencer_if #(
  parameter int HOLD_W = 4
);
  logic [1:0]        req_valid;
  logic [2:0]        req_buttons0;
  logic [2:0]        req_buttons1;
  logic [HOLD_W-1:0] req_hold0;
  logic [HOLD_W-1:0] req_hold1;
  logic [1:0]        req_ready;

  modport master (
    output req_valid,
    output req_buttons0,
    output req_buttons1,
    output req_hold0,
    output req_hold1,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_buttons0,
    input  req_buttons1,
    input  req_hold0,
    input  req_hold1,
    output req_ready
  );
endinterface

// File: rtl/action_sequencer.sv
// Round-robin command queue that replays timed button patterns
// into the character FSM and reports each command's outcome.
module action_sequencer #(
  parameter int DEPTH  = 4,
  parameter int HOLD_W = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  action_sequencer_if.slave        req,
  input  logic [1:0]               action,
  output logic [2:0]               buttons,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     done,
  output logic                     done_id,
  output logic [1:0]               done_action
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [CW-1:0]     FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0]     ONE_C  = CW'(1);
  localparam logic [PW-1:0]     ONE_P  = PW'(1);
  localparam logic [HOLD_W-1:0] ONE_H  = HOLD_W'(1);

  typedef struct packed {
    logic              id;
    logic [2:0]        btn;
    logic [HOLD_W-1:0] hold;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    RELEASE
  } state_t;

  entry_t            mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              prio_q, prio_d;
  state_t            state_q, state_d;
  logic [2:0]        buttons_q, buttons_d;
  logic [HOLD_W-1:0] hcnt_q, hcnt_d;
  logic              cur_id_q, cur_id_d;
  logic              done_q, done_d;
  logic              done_id_q, done_id_d;
  logic [1:0]        done_act_q, done_act_d;

  logic [1:0] gnt;
  logic       full;
  logic       push;
  logic       pop;
  entry_t     wr_entry;
  entry_t     head;

  assign full = (count_q == FULL_C);
  assign head = mem_q[rd_ptr_q];

  // prio_q set means requester 1 is favoured on a tie
  always_comb begin
    gnt = 2'b00;
    if (!reset && !full) begin
      unique case (req.req_valid)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = prio_q ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  assign req.req_ready = gnt;
  assign push          = |gnt;

  always_comb begin
    wr_entry = '0;
    if (gnt[1]) begin
      wr_entry.id   = 1'b1;
      wr_entry.btn  = req.req_buttons1;
      wr_entry.hold = req.req_hold1;
    end else begin
      wr_entry.id   = 1'b0;
      wr_entry.btn  = req.req_buttons0;
      wr_entry.hold = req.req_hold0;
    end
  end

  always_comb begin
    prio_d   = prio_q;
    wr_ptr_d = wr_ptr_q;
    if (push) begin
      prio_d   = ~gnt[1];
      wr_ptr_d = wr_ptr_q + ONE_P;
    end
  end

  always_comb begin
    state_d    = state_q;
    buttons_d  = buttons_q;
    hcnt_d     = hcnt_q;
    cur_id_d   = cur_id_q;
    done_d     = 1'b0;
    done_id_d  = done_id_q;
    done_act_d = done_act_q;
    pop        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop       = 1'b1;
          buttons_d = head.btn;
          hcnt_d    = (head.hold == '0) ? '0 : head.hold - ONE_H;
          cur_id_d  = head.id;
          state_d   = DRIVE;
        end else begin
          buttons_d = 3'b000;
        end
      end
      DRIVE: begin
        if (hcnt_q != '0) begin
          hcnt_d = hcnt_q - ONE_H;
        end else begin
          buttons_d  = 3'b000;
          done_d     = 1'b1;
          done_id_d  = cur_id_q;
          done_act_d = action;
          state_d    = RELEASE;
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        buttons_d = 3'b000;
        state_d   = IDLE;
      end
    endcase
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + ONE_P;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      prio_q     <= 1'b0;
      state_q    <= IDLE;
      buttons_q  <= 3'b000;
      hcnt_q     <= '0;
      cur_id_q   <= 1'b0;
      done_q     <= 1'b0;
      done_id_q  <= 1'b0;
      done_act_q <= 2'b00;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      prio_q     <= prio_d;
      state_q    <= state_d;
      buttons_q  <= buttons_d;
      hcnt_q     <= hcnt_d;
      cur_id_q   <= cur_id_d;
      done_q     <= done_d;
      done_id_q  <= done_id_d;
      done_act_q <= done_act_d;
    end
  end

  assign buttons     = buttons_q;
  assign count       = count_q;
  assign done        = done_q;
  assign done_id     = done_id_q;
  assign done_action = done_act_q;
  assign busy        = (count_q != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_action_sequencer.sv
// Directed bench for action_sequencer with a small character-FSM
// stand-in driving the action input.
module tb_action_sequencer;

  localparam logic [1:0] S = 2'b00;
  localparam logic [1:0] J = 2'b01;
  localparam logic [1:0] D = 2'b10;
  localparam logic [1:0] R = 2'b11;

  logic       clk;
  logic       reset;
  logic [1:0] action;
  logic [2:0] buttons;
  logic       busy;
  logic [2:0] count;
  logic       done;
  logic       done_id;
  logic [1:0] done_action;

  logic [1:0] cs;
  logic [1:0] act;

  int n_cmp;
  int n_bad;

  action_sequencer_if #(.HOLD_W(4)) rif ();

  action_sequencer #(
    .DEPTH  (4),
    .HOLD_W (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (rif),
    .action      (action),
    .buttons     (buttons),
    .busy        (busy),
    .count       (count),
    .done        (done),
    .done_id     (done_id),
    .done_action (done_action)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // jump from stand/run, double jump on jump+aux while airborne
  always_comb begin
    act = S;
    if (buttons == 3'b000) begin
      act = S;
    end else if (buttons[2]) begin
      if (cs == S || cs == R) act = J;
      else if (cs == J && buttons[0]) act = D;
      else act = cs;
    end else if (buttons[1]) begin
      act = R;
    end else begin
      act = S;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cs <= S;
    else cs <= act;
  end

  assign action = act;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drive(input logic [1:0] v,
                       input logic [2:0] b0, input logic [3:0] h0,
                       input logic [2:0] b1, input logic [3:0] h1);
    rif.req_valid    = v;
    rif.req_buttons0 = b0;
    rif.req_hold0    = h0;
    rif.req_buttons1 = b1;
    rif.req_hold1    = h1;
    #1;
  endtask

  task automatic do_reset();
    drive(2'b00, 3'b000, 4'd0, 3'b000, 4'd0);
    reset = 1'b1;
    ticks(2);
    reset = 1'b0;
    #1;
  endtask

  logic [2:0] exp_b [5];
  logic       exp_id [5];
  logic [2:0] last_b;
  logic       got;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    exp_b  = '{3'b001, 3'b010, 3'b001, 3'b010, 3'b001};
    exp_id = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    reset = 1'b1;
    drive(2'b11, 3'b010, 4'd3, 3'b001, 4'd3);
    @(negedge clk);
    tick();
    chk("rst_ready", rif.req_ready, 2'b00);
    chk("rst_buttons", buttons, 3'b000);
    chk("rst_count", count, 3'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_done_id", done_id, 1'b0);
    chk("rst_done_act", done_action, 2'b00);

    // single command, run for 3 cycles
    do_reset();
    drive(2'b01, 3'b010, 4'd3, 3'b000, 4'd0);
    chk("a_ready", rif.req_ready, 2'b01);
    tick();
    drive(2'b00, 3'b000, 4'd0, 3'b000, 4'd0);
    chk("a_count1", count, 3'd1);
    chk("a_btn_idle", buttons, 3'b000);
    chk("a_busy", busy, 1'b1);
    tick();
    chk("a_btn1", buttons, 3'b010);
    chk("a_count0", count, 3'd0);
    tick();
    chk("a_btn2", buttons, 3'b010);
    tick();
    chk("a_btn3", buttons, 3'b010);
    chk("a_nodone", done, 1'b0);
    tick();
    chk("a_btn_rel", buttons, 3'b000);
    chk("a_done", done, 1'b1);
    chk("a_done_id", done_id, 1'b0);
    chk("a_done_act", done_action, 2'b11);
    tick();
    chk("a_done_off", done, 1'b0);
    chk("a_idle_busy", busy, 1'b0);
    chk("a_act_hold", done_action, 2'b11);

    // contention, fill, full-with-pop
    do_reset();
    drive(2'b11, 3'b010, 4'd15, 3'b001, 4'd15);
    chk("b_g0", rif.req_ready, 2'b01);
    tick();
    chk("b_g1", rif.req_ready, 2'b10);
    tick();
    chk("b_g2", rif.req_ready, 2'b01);
    chk("b_btn", buttons, 3'b010);
    tick();
    chk("b_g3", rif.req_ready, 2'b10);
    tick();
    chk("b_g4", rif.req_ready, 2'b01);
    tick();
    chk("b_count4", count, 3'd4);
    chk("b_full_ready", rif.req_ready, 2'b00);
    ticks(12);
    chk("b_done0", done, 1'b1);
    chk("b_done0_id", done_id, 1'b0);
    chk("b_done0_act", done_action, 2'b11);
    chk("b_full_ready2", rif.req_ready, 2'b00);
    tick();
    chk("b_pop_count", count, 3'd4);
    chk("b_pop_ready", rif.req_ready, 2'b00);
    tick();
    chk("b_count3", count, 3'd3);
    chk("b_regrant", rif.req_ready, 2'b10);
    chk("b_btn_e1", buttons, 3'b001);
    tick();
    chk("b_refill", count, 3'd4);
    drive(2'b00, 3'b000, 4'd0, 3'b000, 4'd0);
    for (int i = 0; i < 5; i++) begin
      got = 1'b0;
      last_b = 3'b000;
      for (int t = 0; t < 40 && !got; t++) begin
        if (buttons != 3'b000) last_b = buttons;
        if (done) got = 1'b1;
        else tick();
      end
      chk("b_order_seen", got, 1'b1);
      chk("b_order_id", done_id, exp_id[i]);
      chk("b_order_btn", last_b, exp_b[i]);
      tick();
    end
    chk("b_drained", busy, 1'b0);

    // hold 0 from requester 1
    do_reset();
    drive(2'b10, 3'b000, 4'd0, 3'b110, 4'd0);
    chk("c_ready", rif.req_ready, 2'b10);
    tick();
    drive(2'b00, 3'b000, 4'd0, 3'b000, 4'd0);
    tick();
    chk("c_btn", buttons, 3'b110);
    chk("c_nodone", done, 1'b0);
    tick();
    chk("c_btn_rel", buttons, 3'b000);
    chk("c_done", done, 1'b1);
    chk("c_done_id", done_id, 1'b1);

    // double jump
    do_reset();
    drive(2'b01, 3'b101, 4'd2, 3'b000, 4'd0);
    tick();
    drive(2'b00, 3'b000, 4'd0, 3'b000, 4'd0);
    chk("d_act_s", action, S);
    tick();
    chk("d_btn", buttons, 3'b101);
    chk("d_act_j", action, J);
    tick();
    chk("d_act_d", action, D);
    tick();
    chk("d_done", done, 1'b1);
    chk("d_done_act", done_action, D);
    chk("d_act_back", action, S);

    // reset during the second DRIVE cycle
    do_reset();
    drive(2'b01, 3'b100, 4'd4, 3'b000, 4'd0);
    chk("e_ready", rif.req_ready, 2'b01);
    ticks(3);
    chk("e_count2", count, 3'd2);
    chk("e_btn", buttons, 3'b100);
    reset = 1'b1;
    drive(2'b11, 3'b100, 4'd4, 3'b011, 4'd4);
    chk("e_rst_ready", rif.req_ready, 2'b00);
    tick();
    reset = 1'b0;
    #1;
    chk("e_btn0", buttons, 3'b000);
    chk("e_count0", count, 3'd0);
    chk("e_busy0", busy, 1'b0);
    chk("e_nodone", done, 1'b0);
    chk("e_prio0", rif.req_ready, 2'b01);
    tick();
    drive(2'b00, 3'b000, 4'd0, 3'b000, 4'd0);
    chk("e_nodone2", done, 1'b0);
    chk("e_count1", count, 3'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
